fft_source_collector: RTL

Output-side companion to the FFT input controller: accepts the FFT core's Avalon-ST source stream (complex bins with sop/eop/valid/error), enforces frame framing, and converts each bin to a squared magnitude with bin index for downstream spectrum logic. Applies backpressure to the FFT via `source_ready`, drops malformed beats, and reports frame completion and framing errors.

---
 rtl/fft_stream_pkg.sv | 21 ++
 rtl/mag_sq_pipe.sv | 75 +++++++
 rtl/fft_source_collector.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/fft_stream_pkg.sv
// Shared definitions for the FFT source-side stream logic: error codes,
// framing FSM states and default geometry.
package fft_stream_pkg;

  localparam int DEF_FFT_PTS = 1024;
  localparam int DEF_DW      = 12;

  localparam logic [2:0] ERR_NONE      = 3'd0;
  localparam logic [2:0] ERR_NO_SOP    = 3'd1;
  localparam logic [2:0] ERR_EARLY_SOP = 3'd2;
  localparam logic [2:0] ERR_EARLY_EOP = 3'd3;
  localparam logic [2:0] ERR_NO_EOP    = 3'd4;
  localparam logic [2:0] ERR_CORE      = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FRAME,
    ST_DROP
  } state_e;

endpackage

// File: rtl/mag_sq_pipe.sv
// Two-stage squared-magnitude pipeline: stage 1 registers re^2 and im^2,
// stage 2 registers their sum. A sideband word rides along; en=0 freezes both.
module mag_sq_pipe #(
  parameter int DW = 12,
  parameter int SW = 13
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          in_valid,
  input  logic [DW-1:0] in_re,
  input  logic [DW-1:0] in_im,
  input  logic [SW-1:0] in_side,
  output logic          out_valid,
  output logic [2*DW:0] out_data,
  output logic [SW-1:0] out_side
);

  logic signed [2*DW-1:0] re_ext, im_ext, re_sq, im_sq;
  logic                   v1_q, v1_d, v2_q, v2_d;
  logic [2*DW-1:0]        re_sq_q, re_sq_d, im_sq_q, im_sq_d;
  logic [SW-1:0]          side1_q, side1_d, side2_q, side2_d;
  logic [2*DW:0]          sum_q, sum_d;

  // Squares of a DW-bit signed value stay below 2^(2*DW-1), so the
  // truncated 2*DW-bit product is exact and non-negative.
  assign re_ext = {{DW{in_re[DW-1]}}, in_re};
  assign im_ext = {{DW{in_im[DW-1]}}, in_im};
  assign re_sq  = re_ext * re_ext;
  assign im_sq  = im_ext * im_ext;

  always_comb begin
    v1_d    = v1_q;
    re_sq_d = re_sq_q;
    im_sq_d = im_sq_q;
    side1_d = side1_q;
    v2_d    = v2_q;
    sum_d   = sum_q;
    side2_d = side2_q;
    if (en) begin
      v1_d    = in_valid;
      re_sq_d = re_sq;
      im_sq_d = im_sq;
      side1_d = in_side;
      v2_d    = v1_q;
      sum_d   = {1'b0, re_sq_q} + {1'b0, im_sq_q};
      side2_d = side1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      re_sq_q <= '0;
      im_sq_q <= '0;
      side1_q <= '0;
      v2_q    <= 1'b0;
      sum_q   <= '0;
      side2_q <= '0;
    end else begin
      v1_q    <= v1_d;
      re_sq_q <= re_sq_d;
      im_sq_q <= im_sq_d;
      side1_q <= side1_d;
      v2_q    <= v2_d;
      sum_q   <= sum_d;
      side2_q <= side2_d;
    end
  end

  assign out_valid = v2_q;
  assign out_data  = sum_q;
  assign out_side  = side2_q;

endmodule

// File: rtl/fft_source_collector.sv
// Collects the FFT core's source stream, enforces sop/eop framing and emits
// per-bin squared magnitudes with index, frame-done and framing-error reports.
module fft_source_collector
  import fft_stream_pkg::*;
#(
  parameter int FFT_PTS = DEF_FFT_PTS,
  parameter int DW      = DEF_DW,
  parameter int BW      = $clog2(FFT_PTS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          source_valid,
  output logic          source_ready,
  input  logic          source_sop,
  input  logic          source_eop,
  input  logic [1:0]    source_error,
  input  logic [DW-1:0] source_real,
  input  logic [DW-1:0] source_imag,
  output logic          mag_valid,
  input  logic          mag_ready,
  output logic [2*DW:0] mag_data,
  output logic [BW-1:0] mag_bin,
  output logic          mag_sop,
  output logic          mag_eop,
  output logic          frame_done,
  output logic          frame_err,
  output logic [2:0]    err_code,
  output logic [15:0]   frame_count
);

  localparam logic [BW-1:0] LAST_BIN = BW'(FFT_PTS - 1);
  localparam int            SW       = BW + 3;

  state_e        state_q, state_d;
  logic [1:0]    rst_sync_q, rst_sync_d;
  logic          rst_core_n;
  logic [BW-1:0] bin_q, bin_d, out_bin;
  logic          bad_q, bad_d;
  logic          frame_err_q, frame_err_d;
  logic [2:0]    err_code_q, err_code_d;
  logic [15:0]   frame_count_q, frame_count_d;
  logic          stall, xfer, core_err, accept, out_eop, out_done, err_hit;
  logic [2:0]    err_val;
  logic [SW-1:0] side_in, side_out;

  // Reset asserts immediately but releases two clocks after rst_n rises.
  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= rst_sync_d;
  end
  assign rst_core_n = rst_sync_q[1];

  assign stall        = mag_valid && !mag_ready;
  assign source_ready = !stall;
  assign xfer         = source_valid && source_ready;
  assign core_err     = (source_error != 2'b00);

  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    bad_d    = bad_q;
    accept   = 1'b0;
    out_bin  = bin_q;
    out_eop  = 1'b0;
    out_done = 1'b0;
    err_hit  = 1'b0;
    err_val  = ERR_NONE;
    if (xfer) begin
      case (state_q)
        ST_FRAME: begin
          if (source_sop) begin
            err_hit = 1'b1;
            err_val = ERR_EARLY_SOP;
            accept  = 1'b1;
            out_bin = '0;
            bin_d   = BW'(1);
            bad_d   = core_err;
          end else if (source_eop && bin_q != LAST_BIN) begin
            err_hit = 1'b1;
            err_val = ERR_EARLY_EOP;
            state_d = ST_IDLE;
          end else if (!source_eop && bin_q == LAST_BIN) begin
            err_hit = 1'b1;
            err_val = ERR_NO_EOP;
            state_d = ST_DROP;
          end else begin
            accept  = 1'b1;
            err_hit = core_err;
            err_val = core_err ? ERR_CORE : ERR_NONE;
            if (bin_q == LAST_BIN) begin
              out_eop  = 1'b1;
              out_done = !bad_q && !core_err;
              state_d  = ST_IDLE;
              bin_d    = '0;
              bad_d    = 1'b0;
            end else begin
              bin_d = bin_q + 1'b1;
              bad_d = bad_q || core_err;
            end
          end
        end
        default: begin
          if (source_sop) begin
            accept  = 1'b1;
            out_bin = '0;
            bin_d   = BW'(1);
            bad_d   = core_err;
            state_d = ST_FRAME;
            err_hit = core_err;
            err_val = core_err ? ERR_CORE : ERR_NONE;
          end else if (state_q == ST_IDLE) begin
            // Only the first stray beat of a run is reported; DROP stays silent.
            err_hit = 1'b1;
            err_val = ERR_NO_SOP;
            state_d = ST_DROP;
          end
        end
      endcase
    end
    frame_err_d   = err_hit;
    err_code_d    = err_hit ? err_val : err_code_q;
    frame_count_d = frame_count_q + {15'd0, frame_done};
  end

  always_ff @(posedge clk or negedge rst_core_n) begin
    if (!rst_core_n) begin
      state_q       <= ST_IDLE;
      bin_q         <= '0;
      bad_q         <= 1'b0;
      frame_err_q   <= 1'b0;
      err_code_q    <= ERR_NONE;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      bin_q         <= bin_d;
      bad_q         <= bad_d;
      frame_err_q   <= frame_err_d;
      err_code_q    <= err_code_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign side_in = {out_done, out_eop, (out_bin == '0), out_bin};

  mag_sq_pipe #(
    .DW (DW),
    .SW (SW)
  ) u_pipe (
    .clk       (clk),
    .rst_n     (rst_core_n),
    .en        (!stall),
    .in_valid  (xfer && accept),
    .in_re     (source_real),
    .in_im     (source_imag),
    .in_side   (side_in),
    .out_valid (mag_valid),
    .out_data  (mag_data),
    .out_side  (side_out)
  );

  assign mag_bin     = side_out[BW-1:0];
  assign mag_sop     = side_out[BW];
  assign mag_eop     = side_out[BW+1];
  assign frame_done  = mag_valid && mag_ready && side_out[BW+2];
  assign frame_err   = frame_err_q;
  assign err_code    = err_code_q;
  assign frame_count = frame_count_q;

endmodule
